// File: rtl/wb_scoreboard_if.sv
// Decode/writeback handshake bundle for the register write scoreboard.
// Pure wiring, no latency of its own.
// Stall is the only backpressure signal; it flows from slave back to master.
interface wb_scoreboard_if;
  logic       IssueValid;
  logic       IssueWrEn;
  logic [2:0] IssueReg;
  logic [2:0] Rs;
  logic [2:0] Rt;
  logic       RtValid;
  logic       WbValid;
  logic [2:0] WbReg;
  logic       Flush;
  logic       Stall;
  logic       IssueAccept;
  logic [7:0] Busy;
  logic [3:0] InFlight;
  logic       Err;

  // Pipeline side: drives issue/retire/flush and obeys Stall.
  modport master (
    output IssueValid, IssueWrEn, IssueReg, Rs, Rt, RtValid, WbValid, WbReg, Flush,
    input  Stall, IssueAccept, Busy, InFlight, Err
  );

  // Scoreboard side.
  modport slave (
    input  IssueValid, IssueWrEn, IssueReg, Rs, Rt, RtValid, WbValid, WbReg, Flush,
    output Stall, IssueAccept, Busy, InFlight, Err
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard: tracks writes issued from decode until writeback.
// Stall/IssueAccept are combinational; Busy/InFlight/Err update one edge after the cause.
// Stall holds decode on a RAW hazard on Rs/Rt or when the total in-flight write budget is full.
module wb_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic            clk,
  input  logic            rst,
  wb_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       INFL_MAX = 4'(MAX_INFLIGHT);

  logic [7:0][CNT_W-1:0] cnt;
  logic [7:0][CNT_W-1:0] cnt_nxt;
  logic [3:0]            inflight;
  logic [3:0]            inflight_nxt;
  logic                  err;
  logic                  err_nxt;
  logic [7:0]            busy;
  logic                  stall;
  logic                  accept;
  logic                  same_reg;

  // Busy bit per register is simply "count is nonzero" on registered state.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      busy[i] = |cnt[i];
    end
  end

  assign stall = sb.IssueValid &
                 (busy[sb.Rs] |
                  (sb.RtValid & busy[sb.Rt]) |
                  (sb.IssueWrEn & (inflight == INFL_MAX)));

  assign accept   = sb.IssueValid & sb.IssueWrEn & ~stall & ~sb.Flush;
  // An issue and a retire to the same register cancel out, including at the
  // counter limits, so neither overflow nor underflow is flagged then.
  assign same_reg = accept & sb.WbValid & (sb.IssueReg == sb.WbReg);

  assign sb.Stall       = stall;
  assign sb.IssueAccept = accept;
  assign sb.Busy        = busy;
  assign sb.InFlight    = inflight;
  assign sb.Err         = err;

  // Next-state: flush wins, otherwise apply issue and retire independently.
  always_comb begin
    cnt_nxt      = cnt;
    inflight_nxt = inflight;
    err_nxt      = err;
    if (sb.Flush) begin
      cnt_nxt      = '0;
      inflight_nxt = '0;
    end else if (!same_reg) begin
      if (accept) begin
        if (cnt[sb.IssueReg] == CNT_MAX) begin
          err_nxt = 1'b1;
        end else begin
          cnt_nxt[sb.IssueReg] = cnt[sb.IssueReg] + 1'b1;
          inflight_nxt         = inflight_nxt + 4'd1;
        end
      end
      if (sb.WbValid) begin
        if (cnt[sb.WbReg] == '0) begin
          err_nxt = 1'b1;
        end else begin
          cnt_nxt[sb.WbReg] = cnt[sb.WbReg] - 1'b1;
          inflight_nxt      = inflight_nxt - 4'd1;
        end
      end
    end
  end

  // State registers; reset drops all pending writes and the sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      inflight <= inflight_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus randomized traffic.
// Randomized section compares against a per-register pending-count model.
// Stimulus is applied 1ns after the rising edge and sampled 1ns later.
module tb_wb_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_scoreboard_if sb_if ();

  wb_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic idle();
    sb_if.IssueValid = 1'b0;
    sb_if.IssueWrEn  = 1'b0;
    sb_if.IssueReg   = 3'd0;
    sb_if.Rs         = 3'd0;
    sb_if.Rt         = 3'd0;
    sb_if.RtValid    = 1'b0;
    sb_if.WbValid    = 1'b0;
    sb_if.WbReg      = 3'd0;
    sb_if.Flush      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic issue(input int r);
    idle();
    sb_if.IssueValid = 1'b1;
    sb_if.IssueWrEn  = 1'b1;
    sb_if.IssueReg   = 3'(r);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #2;
    checks++; if (sb_if.Busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h expected 00", sb_if.Busy); end
    checks++; if (sb_if.InFlight !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", sb_if.InFlight); end
    checks++; if (sb_if.Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sb_if.Err); end
    issue(3);
    sb_if.Rs = 3'd3;
    #1;
    checks++; if (sb_if.Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", sb_if.Stall); end
    checks++; if (sb_if.IssueAccept !== 1'b1) begin errors++; $display("FAIL reset_accept: got %b expected 1", sb_if.IssueAccept); end
    tick();
    checks++; if (sb_if.Busy !== 8'h00) begin errors++; $display("FAIL reset_hold_busy: got %h expected 00", sb_if.Busy); end
    idle();
    rst = 1'b1;
  endtask

  task automatic test_raw_basic();
    do_reset();
    issue(3);
    #1;
    checks++; if (sb_if.IssueAccept !== 1'b1) begin errors++; $display("FAIL raw_accept: got %b expected 1", sb_if.IssueAccept); end
    tick();
    idle();
    sb_if.IssueValid = 1'b1;
    sb_if.Rs = 3'd3;
    #1;
    checks++; if (sb_if.Busy !== 8'h08) begin errors++; $display("FAIL raw_busy: got %h expected 08", sb_if.Busy); end
    checks++; if (sb_if.Stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", sb_if.Stall); end
    tick();
    sb_if.WbValid = 1'b1;
    sb_if.WbReg   = 3'd3;
    #1;
    checks++; if (sb_if.Stall !== 1'b1) begin errors++; $display("FAIL raw_stall_wb_cycle: got %b expected 1", sb_if.Stall); end
    tick();
    sb_if.WbValid = 1'b0;
    #1;
    checks++; if (sb_if.Stall !== 1'b0) begin errors++; $display("FAIL raw_stall_released: got %b expected 0", sb_if.Stall); end
    checks++; if (sb_if.InFlight !== 4'd0) begin errors++; $display("FAIL raw_inflight: got %0d expected 0", sb_if.InFlight); end
    checks++; if (sb_if.Err !== 1'b0) begin errors++; $display("FAIL raw_err: got %b expected 0", sb_if.Err); end
    idle();
  endtask

  task automatic test_rt_valid();
    do_reset();
    issue(5);
    tick();
    idle();
    sb_if.IssueValid = 1'b1;
    sb_if.Rt = 3'd5;
    #1;
    checks++; if (sb_if.Stall !== 1'b0) begin errors++; $display("FAIL rt_unused_stall: got %b expected 0", sb_if.Stall); end
    sb_if.RtValid = 1'b1;
    #1;
    checks++; if (sb_if.Stall !== 1'b1) begin errors++; $display("FAIL rt_used_stall: got %b expected 1", sb_if.Stall); end
    sb_if.IssueValid = 1'b0;
    #1;
    checks++; if (sb_if.Stall !== 1'b0) begin errors++; $display("FAIL rt_invalid_stall: got %b expected 0", sb_if.Stall); end
    idle();
  endtask

  task automatic test_inflight_limit();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue(r);
      #1;
      checks++; if (sb_if.IssueAccept !== 1'b1) begin errors++; $display("FAIL limit_accept_%0d: got %b expected 1", r, sb_if.IssueAccept); end
      tick();
    end
    issue(5);
    #1;
    checks++; if (sb_if.InFlight !== 4'd4) begin errors++; $display("FAIL limit_inflight: got %0d expected 4", sb_if.InFlight); end
    checks++; if (sb_if.Busy !== 8'h1e) begin errors++; $display("FAIL limit_busy: got %h expected 1e", sb_if.Busy); end
    checks++; if (sb_if.Stall !== 1'b1) begin errors++; $display("FAIL limit_stall: got %b expected 1", sb_if.Stall); end
    checks++; if (sb_if.IssueAccept !== 1'b0) begin errors++; $display("FAIL limit_accept_5: got %b expected 0", sb_if.IssueAccept); end
    tick();
    sb_if.IssueWrEn = 1'b0;
    #1;
    checks++; if (sb_if.InFlight !== 4'd4) begin errors++; $display("FAIL limit_inflight_hold: got %0d expected 4", sb_if.InFlight); end
    checks++; if (sb_if.Stall !== 1'b0) begin errors++; $display("FAIL limit_nonwriter_stall: got %b expected 0", sb_if.Stall); end
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue(2);
    tick();
    issue(2);
    sb_if.WbValid = 1'b1;
    sb_if.WbReg   = 3'd2;
    #1;
    checks++; if (sb_if.IssueAccept !== 1'b1) begin errors++; $display("FAIL same_accept: got %b expected 1", sb_if.IssueAccept); end
    tick();
    idle();
    #1;
    checks++; if (sb_if.Busy !== 8'h04) begin errors++; $display("FAIL same_busy: got %h expected 04", sb_if.Busy); end
    checks++; if (sb_if.InFlight !== 4'd1) begin errors++; $display("FAIL same_inflight: got %0d expected 1", sb_if.InFlight); end
    issue(6);
    sb_if.WbValid = 1'b1;
    sb_if.WbReg   = 3'd2;
    tick();
    idle();
    #1;
    checks++; if (sb_if.Busy !== 8'h40) begin errors++; $display("FAIL diff_busy: got %h expected 40", sb_if.Busy); end
    checks++; if (sb_if.InFlight !== 4'd1) begin errors++; $display("FAIL diff_inflight: got %0d expected 1", sb_if.InFlight); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      issue(r);
      tick();
    end
    issue(7);
    sb_if.Flush = 1'b1;
    #1;
    checks++; if (sb_if.InFlight !== 4'd3) begin errors++; $display("FAIL flush_pre_inflight: got %0d expected 3", sb_if.InFlight); end
    checks++; if (sb_if.IssueAccept !== 1'b0) begin errors++; $display("FAIL flush_accept: got %b expected 0", sb_if.IssueAccept); end
    tick();
    idle();
    #1;
    checks++; if (sb_if.Busy !== 8'h00) begin errors++; $display("FAIL flush_busy: got %h expected 00", sb_if.Busy); end
    checks++; if (sb_if.InFlight !== 4'd0) begin errors++; $display("FAIL flush_inflight: got %0d expected 0", sb_if.InFlight); end
    checks++; if (sb_if.Err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b expected 0", sb_if.Err); end
  endtask

  task automatic test_err_and_async_reset();
    do_reset();
    sb_if.WbValid = 1'b1;
    sb_if.WbReg   = 3'd0;
    tick();
    idle();
    #1;
    checks++; if (sb_if.Err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b expected 1", sb_if.Err); end
    checks++; if (sb_if.Busy !== 8'h00) begin errors++; $display("FAIL underflow_busy: got %h expected 00", sb_if.Busy); end
    checks++; if (sb_if.InFlight !== 4'd0) begin errors++; $display("FAIL underflow_inflight: got %0d expected 0", sb_if.InFlight); end
    sb_if.Flush = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (sb_if.Err !== 1'b1) begin errors++; $display("FAIL err_after_flush: got %b expected 1", sb_if.Err); end
    issue(4);
    tick();
    idle();
    #1;
    checks++; if (sb_if.Busy !== 8'h10) begin errors++; $display("FAIL pre_areset_busy: got %h expected 10", sb_if.Busy); end
    rst = 1'b0;
    #1;
    checks++; if (sb_if.Busy !== 8'h00) begin errors++; $display("FAIL areset_busy: got %h expected 00", sb_if.Busy); end
    checks++; if (sb_if.Err !== 1'b0) begin errors++; $display("FAIL areset_err: got %b expected 0", sb_if.Err); end
    checks++; if (sb_if.InFlight !== 4'd0) begin errors++; $display("FAIL areset_inflight: got %0d expected 0", sb_if.InFlight); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_back_to_back_overflow();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(1);
      tick();
    end
    idle();
    #1;
    checks++; if (sb_if.Err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", sb_if.Err); end
    checks++; if (sb_if.InFlight !== 4'd3) begin errors++; $display("FAIL overflow_inflight: got %0d expected 3", sb_if.InFlight); end
  endtask

  task automatic test_random();
    int  mcnt [8];
    bit  merr;
    int  total;
    int  pend [$];
    bit  iv, we, rtv, wv, fl;
    int  ir, rs, rt, wr;
    bit  exp_stall, exp_acc;
    logic [7:0] exp_busy;
    do_reset();
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
    merr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      total = 0;
      pend.delete();
      for (int i = 0; i < 8; i++) begin
        total += mcnt[i];
        if (mcnt[i] > 0) pend.push_back(i);
      end
      iv  = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 3) != 0);
      ir  = $urandom_range(0, 7);
      rs  = $urandom_range(0, 7);
      rt  = $urandom_range(0, 7);
      rtv = $urandom_range(0, 1);
      wv  = $urandom_range(0, 1);
      if (pend.size() > 0 && $urandom_range(0, 19) != 0)
        wr = pend[$urandom_range(0, pend.size() - 1)];
      else
        wr = $urandom_range(0, 7);
      fl  = ($urandom_range(0, 24) == 0);
      sb_if.IssueValid = iv;
      sb_if.IssueWrEn  = we;
      sb_if.IssueReg   = 3'(ir);
      sb_if.Rs         = 3'(rs);
      sb_if.Rt         = 3'(rt);
      sb_if.RtValid    = rtv;
      sb_if.WbValid    = wv;
      sb_if.WbReg      = 3'(wr);
      sb_if.Flush      = fl;
      exp_stall = iv && (mcnt[rs] > 0 || (rtv && mcnt[rt] > 0) || (we && total == 4));
      exp_acc   = iv && we && !exp_stall && !fl;
      #1;
      checks++; if (sb_if.Stall !== exp_stall) begin errors++; $display("FAIL rand_stall c=%0d: got %b expected %b", c, sb_if.Stall, exp_stall); end
      checks++; if (sb_if.IssueAccept !== exp_acc) begin errors++; $display("FAIL rand_accept c=%0d: got %b expected %b", c, sb_if.IssueAccept, exp_acc); end
      tick();
      if (fl) begin
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
      end else if (!(exp_acc && wv && ir == wr)) begin
        if (exp_acc) begin
          if (mcnt[ir] == 3) merr = 1'b1;
          else mcnt[ir]++;
        end
        if (wv) begin
          if (mcnt[wr] == 0) merr = 1'b1;
          else mcnt[wr]--;
        end
      end
      total = 0;
      for (int i = 0; i < 8; i++) begin
        total += mcnt[i];
        exp_busy[i] = (mcnt[i] != 0);
      end
      checks++; if (sb_if.Busy !== exp_busy) begin errors++; $display("FAIL rand_busy c=%0d: got %h expected %h", c, sb_if.Busy, exp_busy); end
      checks++; if (sb_if.InFlight !== 4'(total)) begin errors++; $display("FAIL rand_inflight c=%0d: got %0d expected %0d", c, sb_if.InFlight, total); end
      checks++; if (sb_if.Err !== merr) begin errors++; $display("FAIL rand_err c=%0d: got %b expected %b", c, sb_if.Err, merr); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_basic();
    test_rt_valid();
    test_inflight_limit();
    test_same_cycle();
    test_flush();
    test_err_and_async_reset();
    test_back_to_back_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Write-side register scoreboard for the 5-stage pipeline: records every destination register when an instruction leaves decode, releases it when the writeback stage commits it, and raises `Stall` to hold decode while a source operand still has a write in flight. It sits beside decode. It takes the writer's view of the RAW hazard (issue and retire of writes), in place of comparing only the adjacent stage's `Rd`. It also bounds total in-flight writes.

## Interface
- `CNT_W`, 2: width of each per-register pending-write counter; counter max `(1<<CNT_W)-1` = 3.
- `MAX_INFLIGHT`, 4: maximum total pending writes across all registers (1..15).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low (`rst`=0 clears all state immediately, independent of `clk`).
- `IssueValid`  in  1  decode holds a valid instruction this cycle.
- `IssueWrEn`  in  1  that instruction writes the register file.
- `IssueReg`  in  3  its destination register.
- `Rs`  in  3  first source register of the decode instruction.
- `Rt`  in  3  second source register.
- `RtValid`  in  1  `Rt` is actually read.
- `WbValid`  in  1  writeback stage commits a register write this cycle.
- `WbReg`  in  3  register being written back.
- `Flush`  in  1  pipeline flush (branch/exception); discards all pending writes.
- `Stall`  out  1  hold decode/fetch this cycle (combinational from state and `Rs`/`Rt`/`RtValid`/`IssueValid`).
- `IssueAccept`  out  1  `IssueValid & IssueWrEn & ~Stall & ~Flush`; a write was recorded.
- `Busy`  out  8  bit i set when pending count of register i is nonzero (registered state).
- `InFlight`  out  4  total pending writes (registered).
- `Err`  out  1  sticky error: counter overflow or writeback underflow.

## Operation
- State: eight `CNT_W`-bit counters `cnt[i]`, a 4-bit `InFlight`, and the sticky `Err`.
- Hazard: `Stall = IssueValid & (Busy[Rs] | (RtValid & Busy[Rt]) | (IssueWrEn & InFlight==MAX_INFLIGHT))`. When `IssueValid`=0, `Stall`=0.
- There is no writeback bypass. `Busy` reflects the registered count, so a source whose last pending write retires in cycle N stalls through cycle N and releases in N+1.
- Issue: when `IssueAccept`=1, `cnt[IssueReg]`+1 and `InFlight`+1.
- Retire: when `WbValid`=1, `cnt[WbReg]`-1 and `InFlight`-1.
- Issue and retire in the same cycle:
  - Same register: `cnt` unchanged, `InFlight` unchanged.
  - Different registers: both counters updated, `InFlight` unchanged.
- Overflow: an issue to a register with `cnt`=max sets `Err`, and `cnt`/`InFlight` hold. Unreachable when `MAX_INFLIGHT` ≤ max, since the `InFlight` stall prevents it.
- Underflow: a retire to a register with `cnt`=0 sets `Err`, and `cnt`/`InFlight` hold for that register.
- Flush: at the next edge, all `cnt` and `InFlight` are cleared. Flush has priority over issue and retire in the same cycle, and `IssueAccept` is forced to 0. `Err` is not cleared by flush.
- `Err` clears only on reset.
- All eight registers, including R0, are tracked.

## Timing
- Reset (`rst`=0): `cnt[*]`=0, `Busy`=8'h00, `InFlight`=0, `Err`=0. Consequently `Stall`=0 and `IssueAccept`=`IssueValid&IssueWrEn`.
- `Stall`, `IssueAccept`: combinational, same cycle as their inputs.
- `Busy`, `InFlight`, `Err`: update one edge after the causing issue/retire/flush.
- An issue in cycle N is visible as `Busy` in N+1. A dependent instruction in decode at N+1 stalls until the cycle after its producer's `WbValid`.
- Reset asserted mid-operation drops all pending state immediately. After `rst` deasserts, the first edge behaves as from idle.

## Test plan
- Reset, then `IssueValid`=1/`IssueWrEn`=1/`IssueReg`=3, `Rs`=3 next cycle -> `Busy`=8'h08 and `Stall`=1. Assert `WbValid`,`WbReg`=3 in cycle K -> `Stall`=1 in K, 0 in K+1, `InFlight` back to 0.
- `Rt`=5 busy with `RtValid`=0 -> `Stall`=0; same with `RtValid`=1 -> `Stall`=1.
- Four accepted issues to regs 1,2,3,4 with no retire -> `InFlight`=4. A fifth writing instruction sees `Stall`=1 and `IssueAccept`=0. A non-writing fifth instruction with free sources -> `Stall`=0.
- Same cycle: issue reg 2 and retire reg 2 with `cnt[2]`=1 -> `cnt[2]` stays 1 and `Busy[2]`=1. Issue reg 6 and retire reg 2 -> `Busy` bit 6 set, bit 2 cleared, `InFlight` unchanged.
- With `InFlight`=3 pending, assert `Flush` together with an issue to reg 7 -> `IssueAccept`=0. Next cycle `Busy`=0, `InFlight`=0, `Err` unchanged.
- `WbValid`=1, `WbReg`=0 with nothing pending -> `Err`=1 next cycle, counts stay 0. `Err` stays 1 through `Flush` and clears only on `rst`=0, which also asynchronously zeroes a nonzero `Busy` without a clock edge.
